// File: rtl/car_pkg.sv
// Shared types and constants for the car power/mode control blocks.
// State encoding, shutdown cause codes and the 1 ms tick length.
package car_pkg;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_RUN,
        ST_WARN,
        ST_SHUTDOWN
    } state_t;

    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_BTN    = 2'b01;
    localparam logic [1:0] CAUSE_IDLE   = 2'b10;
    localparam logic [1:0] CAUSE_FORCED = 2'b11;

    localparam int TICK_1MS_CYCLES = 100_000;

endpackage

// File: rtl/btn_debounce_tick.sv
// Power-off button: 2-flop synchronizer, tick-based debounce, single event.
// The event fires once per press; holding keeps the counter saturated.
module btn_debounce_tick #(
    parameter int DEBOUNCE_MS = 10
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic tick,
    input  logic power_off_btn,
    output logic btn_evt
);

    localparam int CW = $clog2(DEBOUNCE_MS) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_MS);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= power_off_btn;
            sync2 <= sync1;
            if (!sync2) begin
                cnt <= '0;
            end else if (tick && cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // High on the tick that brings the count to its limit.
    assign btn_evt = tick && sync2 && (cnt == CNT_MAX - 1'b1);

endmodule

// File: rtl/power_off_sequencer.sv
// Shutdown sequencer: button, idle timeout with blinking warning, forced off.
// Gates the mode enables via engine_en and reports the last shutdown cause.
module power_off_sequencer
    import car_pkg::*;
#(
    parameter int TICK_CYCLES = TICK_1MS_CYCLES,
    parameter int DEBOUNCE_MS = 10,
    parameter int IDLE_MS     = 10_000,
    parameter int WARN_MS     = 3_000,
    parameter int BLINK_MS    = 250
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       engine_on,
    input  logic       power_off_btn,
    input  logic       activity,
    output logic       engine_en,
    output logic       shutdown_req,
    output logic [1:0] shutdown_cause,
    output logic       warn_led
);

    localparam int PW = $clog2(TICK_CYCLES) + 1;
    localparam int IW = $clog2(IDLE_MS) + 1;
    localparam int BW = $clog2(BLINK_MS) + 1;

    localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_MAX   = IW'(IDLE_MS);
    localparam logic [IW-1:0] WARN_AT    = IW'(IDLE_MS - WARN_MS);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);

    state_t        state;
    logic [PW-1:0] pcnt;
    logic          tick;
    logic [IW-1:0] idle;
    logic [IW-1:0] idle_next;
    logic [BW-1:0] blink;
    logic          btn_evt;
    logic          down;
    logic [1:0]    cause_next;

    btn_debounce_tick #(
        .DEBOUNCE_MS(DEBOUNCE_MS)
    ) u_btn (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .power_off_btn(power_off_btn),
        .btn_evt      (btn_evt)
    );

    assign tick = (pcnt == TICK_LAST);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
        end
    end

    always_comb begin
        idle_next = idle;
        if (tick && idle != IDLE_MAX) begin
            idle_next = idle + 1'b1;
        end
    end

    // Shutdown decision: forced beats button beats idle beats activity.
    always_comb begin
        down       = 1'b0;
        cause_next = shutdown_cause;
        if (state == ST_RUN || state == ST_WARN) begin
            if (!engine_on) begin
                down       = 1'b1;
                cause_next = CAUSE_FORCED;
            end else if (btn_evt) begin
                down       = 1'b1;
                cause_next = CAUSE_BTN;
            end else if (state == ST_WARN && tick && idle_next == IDLE_MAX) begin
                down       = 1'b1;
                cause_next = CAUSE_IDLE;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_OFF;
            engine_en      <= 1'b0;
            shutdown_req   <= 1'b0;
            shutdown_cause <= CAUSE_NONE;
            warn_led       <= 1'b0;
            idle           <= '0;
            blink          <= '0;
        end else begin
            shutdown_req <= 1'b0;
            if (down) begin
                state          <= ST_SHUTDOWN;
                shutdown_req   <= 1'b1;
                shutdown_cause <= cause_next;
                engine_en      <= 1'b0;
                warn_led       <= 1'b0;
                idle           <= '0;
            end else begin
                unique case (state)
                    ST_OFF: begin
                        idle  <= '0;
                        blink <= '0;
                        if (engine_on) begin
                            state          <= ST_RUN;
                            engine_en      <= 1'b1;
                            shutdown_cause <= CAUSE_NONE;
                        end
                    end
                    ST_RUN: begin
                        if (activity) begin
                            idle <= '0;
                        end else if (tick && idle_next == WARN_AT) begin
                            state    <= ST_WARN;
                            warn_led <= 1'b1;
                            blink    <= '0;
                            idle     <= idle_next;
                        end else begin
                            idle <= idle_next;
                        end
                    end
                    ST_WARN: begin
                        if (activity) begin
                            state    <= ST_RUN;
                            warn_led <= 1'b0;
                            idle     <= '0;
                        end else begin
                            idle <= idle_next;
                            if (tick) begin
                                if (blink == BLINK_LAST) begin
                                    blink    <= '0;
                                    warn_led <= ~warn_led;
                                end else begin
                                    blink <= blink + 1'b1;
                                end
                            end
                        end
                    end
                    ST_SHUTDOWN: begin
                        if (!engine_on) begin
                            state <= ST_OFF;
                        end
                    end
                    default: state <= ST_OFF;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_power_off_sequencer.sv
// Bench for power_off_sequencer: vector table through a scoreboard queue,
// plus hand sequences for held button and asynchronous reset.
module tb_power_off_sequencer;

    localparam int TICK_CYCLES = 10;
    localparam int DEBOUNCE_MS = 3;
    localparam int IDLE_MS     = 20;
    localparam int WARN_MS     = 8;
    localparam int BLINK_MS    = 2;

    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic       engine_on;
    logic       power_off_btn;
    logic       activity;
    logic       engine_en;
    logic       shutdown_req;
    logic [1:0] shutdown_cause;
    logic       warn_led;

    power_off_sequencer #(
        .TICK_CYCLES(TICK_CYCLES),
        .DEBOUNCE_MS(DEBOUNCE_MS),
        .IDLE_MS    (IDLE_MS),
        .WARN_MS    (WARN_MS),
        .BLINK_MS   (BLINK_MS)
    ) dut (
        .sys_clk       (sys_clk),
        .rst_n         (rst_n),
        .engine_on     (engine_on),
        .power_off_btn (power_off_btn),
        .activity      (activity),
        .engine_en     (engine_en),
        .shutdown_req  (shutdown_req),
        .shutdown_cause(shutdown_cause),
        .warn_led      (warn_led)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        string      name;
        bit         rst;
        logic       eo;
        logic       btn;
        logic       act;
        int         n;
        logic [4:0] exp;
    } vec_t;

    vec_t       tbl[$];
    logic [4:0] exp_q[$];
    string      name_q[$];
    int         checks = 0;
    int         failures = 0;
    int         req_seen = 0;
    int         req_mark;

    always @(posedge sys_clk) begin
        if (shutdown_req === 1'b1) req_seen++;
    end

    function automatic vec_t mk(
        input string      name,
        input bit         rst,
        input logic       eo,
        input logic       btn,
        input logic       act,
        input int         n,
        input logic       en,
        input logic       req,
        input logic [1:0] cause,
        input logic       led
    );
        vec_t v;
        v.name = name;
        v.rst  = rst;
        v.eo   = eo;
        v.btn  = btn;
        v.act  = act;
        v.n    = n;
        v.exp  = {en, req, cause, led};
        return v;
    endfunction

    function automatic logic [4:0] outs();
        return {engine_en, shutdown_req, shutdown_cause, warn_led};
    endfunction

    task automatic check(input string name, input logic [4:0] got,
                         input logic [4:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: en/req/cause/led got %b required %b",
                     name, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    // Entered and left on a negedge; rst rows restart the tick phase.
    task automatic apply(input vec_t v);
        if (v.rst) begin
            rst_n = 1'b0;
            engine_on = 1'b0;
            power_off_btn = 1'b0;
            activity = 1'b0;
            repeat (2) @(negedge sys_clk);
        end
        engine_on = v.eo;
        power_off_btn = v.btn;
        activity = v.act;
        rst_n = 1'b1;
        exp_q.push_back(v.exp);
        name_q.push_back(v.name);
        repeat (v.n) @(negedge sys_clk);
        check(name_q.pop_front(), outs(), exp_q.pop_front());
    endtask

    initial begin
        #200_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        engine_on = 1'b0;
        power_off_btn = 1'b0;
        activity = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("reset", outs(), 5'b00000);

        // Idle path: WARN at tick 12, blink every 2 ticks, shutdown at 20.
        tbl.push_back(mk("a_on",       1, 1, 0, 0,   1, 1, 0, 2'd0, 0));
        tbl.push_back(mk("a_pre_warn", 0, 1, 0, 0, 118, 1, 0, 2'd0, 0));
        tbl.push_back(mk("a_warn",     0, 1, 0, 0,   1, 1, 0, 2'd0, 1));
        tbl.push_back(mk("a_led_hold", 0, 1, 0, 0,  19, 1, 0, 2'd0, 1));
        tbl.push_back(mk("a_led_off",  0, 1, 0, 0,   1, 1, 0, 2'd0, 0));
        tbl.push_back(mk("a_led_on",   0, 1, 0, 0,  20, 1, 0, 2'd0, 1));
        tbl.push_back(mk("a_led_off2", 0, 1, 0, 0,  20, 1, 0, 2'd0, 0));
        tbl.push_back(mk("a_pre_idle", 0, 1, 0, 0,  19, 1, 0, 2'd0, 0));
        tbl.push_back(mk("a_idle",     0, 1, 0, 0,   1, 0, 1, 2'd2, 0));
        tbl.push_back(mk("a_req_end",  0, 1, 0, 0,   1, 0, 0, 2'd2, 0));
        tbl.push_back(mk("a_stay_sd",  0, 1, 0, 0,  10, 0, 0, 2'd2, 0));
        tbl.push_back(mk("a_off",      0, 0, 0, 0,   1, 0, 0, 2'd2, 0));
        tbl.push_back(mk("a_repower",  0, 1, 0, 0,   1, 1, 0, 2'd0, 0));
        // Activity at tick 15 in WARN; next WARN at tick 27.
        tbl.push_back(mk("b_on",       1, 1, 0, 0,   1, 1, 0, 2'd0, 0));
        tbl.push_back(mk("b_warn",     0, 1, 0, 0, 138, 1, 0, 2'd0, 1));
        tbl.push_back(mk("b_blink",    0, 1, 0, 0,  10, 1, 0, 2'd0, 0));
        tbl.push_back(mk("b_act",      0, 1, 0, 1,   1, 1, 0, 2'd0, 0));
        tbl.push_back(mk("b_run",      0, 1, 0, 0, 119, 1, 0, 2'd0, 0));
        tbl.push_back(mk("b_rewarn",   0, 1, 0, 0,   1, 1, 0, 2'd0, 1));
        // Button: 2-tick glitch ignored, then a real press.
        tbl.push_back(mk("c_on",       1, 1, 0, 0,   1, 1, 0, 2'd0, 0));
        tbl.push_back(mk("c_idle",     0, 1, 0, 0,   9, 1, 0, 2'd0, 0));
        tbl.push_back(mk("c_glitch",   0, 1, 1, 0,  20, 1, 0, 2'd0, 0));
        tbl.push_back(mk("c_release",  0, 1, 0, 0,  30, 1, 0, 2'd0, 0));
        tbl.push_back(mk("c_hold",     0, 1, 1, 0,  29, 1, 0, 2'd0, 0));
        tbl.push_back(mk("c_btn",      0, 1, 1, 0,   1, 0, 1, 2'd1, 0));
        tbl.push_back(mk("c_btn_end",  0, 1, 1, 0,   1, 0, 0, 2'd1, 0));
        tbl.push_back(mk("c_keep",     0, 1, 1, 0, 100, 0, 0, 2'd1, 0));
        // Forced off, cause held through OFF, cleared on re-power.
        tbl.push_back(mk("d_on",       1, 1, 0, 0,   1, 1, 0, 2'd0, 0));
        tbl.push_back(mk("d_run",      0, 1, 0, 0,   5, 1, 0, 2'd0, 0));
        tbl.push_back(mk("d_drop",     0, 0, 0, 0,   1, 0, 1, 2'd3, 0));
        tbl.push_back(mk("d_off",      0, 0, 0, 0,   1, 0, 0, 2'd3, 0));
        tbl.push_back(mk("d_hold",     0, 0, 0, 0,  10, 0, 0, 2'd3, 0));
        tbl.push_back(mk("d_repower",  0, 1, 0, 0,   1, 1, 0, 2'd0, 0));
        // Button event on the same tick as idle count 20.
        tbl.push_back(mk("e_on",       1, 1, 0, 0,   1, 1, 0, 2'd0, 0));
        tbl.push_back(mk("e_warn",     0, 1, 0, 0, 173, 1, 0, 2'd0, 1));
        tbl.push_back(mk("e_press",    0, 1, 1, 0,  25, 1, 0, 2'd0, 0));
        tbl.push_back(mk("e_both",     0, 1, 1, 0,   1, 0, 1, 2'd1, 0));
        // Activity on the tick-12 threshold keeps RUN.
        tbl.push_back(mk("f_on",       1, 1, 0, 0,   1, 1, 0, 2'd0, 0));
        tbl.push_back(mk("f_pre",      0, 1, 0, 0, 118, 1, 0, 2'd0, 0));
        tbl.push_back(mk("f_act",      0, 1, 0, 1,   1, 1, 0, 2'd0, 0));
        tbl.push_back(mk("f_run",      0, 1, 0, 0, 119, 1, 0, 2'd0, 0));
        tbl.push_back(mk("f_warn",     0, 1, 0, 0,   1, 1, 0, 2'd0, 1));

        foreach (tbl[i]) apply(tbl[i]);

        // Held button: exactly one shutdown request.
        apply(mk("g_on", 1, 1, 0, 0, 1, 1, 0, 2'd0, 0));
        req_mark = req_seen;
        apply(mk("g_hold", 0, 1, 1, 0, 150, 0, 0, 2'd1, 0));
        check_int("g_req_count", req_seen - req_mark, 1);

        // Asynchronous reset in WARN with the LED lit.
        apply(mk("h_on", 1, 1, 0, 0, 1, 1, 0, 2'd0, 0));
        apply(mk("h_warn", 0, 1, 0, 0, 124, 1, 0, 2'd0, 1));
        req_mark = req_seen;
        #2;
        rst_n = 1'b0;
        #1;
        check("h_rst_async", outs(), 5'b00000);
        repeat (3) @(negedge sys_clk);
        check("h_rst_hold", outs(), 5'b00000);
        check_int("h_no_req", req_seen - req_mark, 0);
        rst_n = 1'b1;
        @(negedge sys_clk);
        check("h_release", outs(), 5'b10000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
